// File: rtl/ring_nic.sv
// ring_nic: PE-side network interface with one inbound and one outbound packet buffer, VC-polarity gated injection.
module ring_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);
    logic [DATA_WIDTH-1:0] icb, ocb, rd_data;
    logic ics_full, ocs_full, rd, wr;
    assign rd = nicEn & ~nicWrEn;
    assign wr = nicEn & nicWrEn;
    assign net_ri = reset & ~ics_full;
    assign net_so = reset & ocs_full & net_ro & (net_polarity == ocb[DATA_WIDTH-1]);
    assign net_do = ocb;
    always_comb begin
        rd_data = addr == 2'b00 ? icb :
                  addr == 2'b01 ? {{(DATA_WIDTH-1){1'b0}}, ics_full} :
                  addr == 2'b10 ? ocb : {{(DATA_WIDTH-1){1'b0}}, ocs_full};
    end
    // arrival and read-clear never coincide: arrival needs ics_full==0, clear needs ics_full==1
    always_ff @(posedge clk) begin
        if (!reset) begin
            icb      <= '0;
            ocb      <= '0;
            ics_full <= 1'b0;
            ocs_full <= 1'b0;
            d_out    <= '0;
        end else begin
            if (net_si && net_ri) begin
                icb      <= net_di;
                ics_full <= 1'b1;
            end else if (rd && addr == 2'b00) begin
                ics_full <= 1'b0;
            end
            if (net_so)
                ocs_full <= 1'b0;
            else if (wr && addr == 2'b10 && !ocs_full) begin
                ocb      <= d_in;
                ocs_full <= 1'b1;
            end
            if (rd)
                d_out <= rd_data;
        end
    end
endmodule

// File: tb/tb_ring_nic.sv
// tb_ring_nic: directed self-checking bench for ring_nic.
module tb_ring_nic;
    logic clk = 1'b0, reset = 1'b0;
    logic [1:0] addr = '0;
    logic [63:0] d_in = '0, d_out, net_di = '0, net_do;
    logic nicEn = 1'b0, nicWrEn = 1'b0, net_si = 1'b0, net_ri, net_so, net_ro = 1'b0, pol = 1'b0;
    int tests = 0, fails = 0;
    logic seen;

    ring_nic #(.DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(pol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pol <= reset ? ~pol : 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        net_ro = 1'b1;
        tick(); tick();
        check("rst_dout", d_out, 64'h0);
        check("rst_ri", {63'b0, net_ri}, 64'h0);
        check("rst_so", {63'b0, net_so}, 64'h0);
        net_ro = 1'b0;
        reset = 1'b1;
        tick();
        check("ri_after_rst", {63'b0, net_ri}, 64'h1);
        rd(2'b01); check("ics_rst", d_out, 64'h0);
        rd(2'b11); check("ocs_rst", d_out, 64'h0);

        net_di = 64'h0000_0001_DEAD_BEEF; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        check("ri_full", {63'b0, net_ri}, 64'h0);
        rd(2'b01); check("ics_full", d_out, 64'h1);
        rd(2'b00); check("icb_data", d_out, 64'h0000_0001_DEAD_BEEF);
        check("ri_cleared", {63'b0, net_ri}, 64'h1);
        rd(2'b01); check("ics_clear", d_out, 64'h0);
        tick();
        check("dout_hold", d_out, 64'h0);

        net_ro = 1'b1;
        wr(2'b10, 64'h8000_0000_0000_00AA);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!seen) begin
                check("so_vs_pol", {63'b0, net_so}, {63'b0, pol});
                if (net_so) begin
                    check("do_aa", net_do, 64'h8000_0000_0000_00AA);
                    seen = 1'b1;
                end
                tick();
            end
        end
        check("inj1_seen", {63'b0, seen}, 64'h1);
        rd(2'b11); check("ocs_after_inj", d_out, 64'h0);

        net_ro = 1'b0;
        wr(2'b10, 64'h0000_0000_0000_0055);
        for (int i = 0; i < 5; i++) begin
            check("so_blocked", {63'b0, net_so}, 64'h0);
            tick();
        end
        wr(2'b10, 64'h1234);
        rd(2'b10); check("ocb_kept", d_out, 64'h55);
        net_ro = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!seen) begin
                if (net_so) begin
                    check("do_55", net_do, 64'h55);
                    check("pol_0", {63'b0, pol}, 64'h0);
                    seen = 1'b1;
                end
                tick();
            end
        end
        check("inj2_seen", {63'b0, seen}, 64'h1);
        rd(2'b11); check("ocs_after_inj2", d_out, 64'h0);

        net_di = 64'hAAAA; net_si = 1'b1;
        tick();
        net_di = 64'hBBBB;
        tick();
        net_si = 1'b0;
        rd(2'b00); check("icb_first", d_out, 64'hAAAA);
        net_di = 64'hCCCC; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        rd(2'b00); check("icb_next", d_out, 64'hCCCC);
        rd(2'b00); check("icb_stale", d_out, 64'hCCCC);
        rd(2'b01); check("ics_empty", d_out, 64'h0);

        net_ro = 1'b0;
        wr(2'b10, 64'h8000_0000_0000_0001);
        rd(2'b11); check("ocs_set", d_out, 64'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("so_post_rst", {63'b0, net_so}, 64'h0);
        net_ro = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (net_so) seen = 1'b1;
            tick();
        end
        check("no_inj_post_rst", {63'b0, seen}, 64'h0);
        rd(2'b11); check("ocs_post_rst", d_out, 64'h0);
        rd(2'b10); check("ocb_post_rst", d_out, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_nic.md
# ring_nic

Network interface controller between one processing element (PE) and the PE port of one router node in the 4-node bidirectional ring. It exposes a 4-word register map to the processor and holds one inbound and one outbound 64-bit packet. Outbound packets are injected into the router only when the ring polarity matches the packet's virtual-channel bit. One instance sits beside each router node.

## Interface
- DATA_WIDTH, 64, packet/register width; bit 63 is the VC bit, compared against polarity.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- addr  in  2  register select: 00 ICB, 01 ICS, 10 OCB, 11 OCS
- d_in  in  DATA_WIDTH  processor write data
- d_out  out  DATA_WIDTH  processor read data, registered
- nicEn  in  1  register access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  in  1  router delivering a packet (router peso)
- net_ri  out  1  NIC can accept a packet (to router pero)
- net_di  in  DATA_WIDTH  inbound packet (router pedo)
- net_so  out  1  NIC injecting a packet (to router pesi)
- net_ro  in  1  router can accept a packet (router peri)
- net_do  out  DATA_WIDTH  outbound packet (to router pedi)
- net_polarity  in  1  ring polarity, toggles every cycle after reset

## Operation
- State: ICB (64-bit), ics_full, OCB (64-bit), ocs_full, d_out register.
- Reset (reset==0 at edge): ics_full=0, ocs_full=0, ICB=0, OCB=0, d_out=0. While reset==0, net_ri=0 and net_so=0 regardless of other state.
- Inbound: net_ri = reset & ~ics_full (combinational from registers). Edge with net_si & net_ri: ICB<=net_di, ics_full<=1. net_si while net_ri==0 is ignored; ICB unchanged.
- Outbound: net_so = reset & ocs_full & net_ro & (net_polarity == OCB[63]); net_do = OCB at all times. Edge with net_so==1: ocs_full<=0 (OCB contents retained).
- Processor read (nicEn & ~nicWrEn), d_out loaded at edge:
  - 00: d_out<=ICB; if ics_full, ics_full<=0. Read when empty returns stale ICB, no state change.
  - 01: d_out<={63'b0, ics_full}.
  - 10: d_out<=OCB.
  - 11: d_out<={63'b0, ocs_full}.
- Processor write (nicEn & nicWrEn):
  - 10: if ocs_full==0 at the edge, OCB<=d_in, ocs_full<=1; else write dropped, OCB unchanged.
  - 00, 01, 11: ignored.
- nicEn==0: d_out holds previous value; no register side effects.
- Simultaneous events:
  - Write to OCB in the same cycle the OCB is injected: ocs_full is 1 at that edge, so the write is dropped.
  - ICB read-clear and packet arrival cannot coincide (net_ri==0 while full); arrival possible from the cycle after the clearing edge.
  - Inbound and outbound paths are independent; both may fire on one edge.
- Reset asserted mid-operation: buffered packets discarded, flags cleared at that edge, no partial injection afterwards.

## Timing
- Read latency 1 cycle: request sampled at edge n, d_out valid after edge n until the next enabled read.
- Inbound: packet sampled at edge k; ics_full=1 and net_ri=0 after edge k; ICS read issued in cycle k+1 returns 1.
- ICB read at edge m clears ics_full; net_ri=1 after edge m.
- Outbound: OCB written at edge w; net_so may assert in cycle w+1 at the earliest. With net_ro=1 constantly, injection occurs within at most 2 cycles (polarity alternates).
- net_so/net_ri have no registered delay relative to their inputs; the router samples them at the next edge.
- Throughput: one inbound and one outbound packet per 2 cycles max (set, then clear).

## Test plan
- Reset with reset=0 for 2 cycles -> d_out=0, net_ri=0, net_so=0 during reset; after release net_ri=1, ICS/OCS reads return 0.
- Router delivers net_di=64'h0000_0001_DEAD_BEEF with net_si=1 -> net_ri=0 next cycle; ICS read=1; ICB read returns 64'h0000_0001_DEAD_BEEF; ICS read afterwards=0, net_ri=1.
- Write OCB=64'h8000_0000_0000_00AA, net_ro=1 -> net_so asserts only in the cycle net_polarity=1, net_do=64'h8000_0000_0000_00AA; OCS=0 after that edge.
- OCB full and net_ro=0 for 5 cycles; write 64'h1234 to addr 10 -> write dropped; after net_ro=1, injected packet is the original, OCS then 0.
- Second packet offered with net_si=1 while ICB full -> ICB unchanged; after ICB read, the next net_si packet is captured.
- OCB full, reset pulled low mid-wait for 1 cycle -> ocs_full=0, net_so never asserts afterwards without a new write.
